// File: rtl/fmc_adc_acq_trig_buf.sv
// Pre/post-trigger capture buffer: circular history while armed, post-trigger window,
// then a valid/ready readout of pre+post beats from a synchronous dual-port RAM.
module fmc_adc_acq_trig_buf #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [16*NUM_CH-1:0]  s_data,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig_in,
  input  logic                  trig_sw,
  input  logic [ADDR_W:0]       cfg_pre,
  input  logic [ADDR_W:0]       cfg_post,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [16*NUM_CH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [2:0]            state,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic                  cfg_err,
  output logic                  done
);

  localparam int DW = 16 * NUM_CH;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_READ = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       pre_q, pre_d, post_q, post_d, len_q, len_d, cnt_q, cnt_d;
  logic [CW-1:0]       rd_left_q, rd_left_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d, trig_addr_q, trig_addr_d, rd_addr_q, rd_addr_d;
  logic                trig_q;
  logic                rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [DW-1:0]       m_data_q, m_data_d;
  logic                skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic [DW-1:0]       skid_data_q, skid_data_d;
  logic                cfg_err_q, cfg_err_d, done_q, done_d;
  logic [DW-1:0]       ram_q;
  logic [DW-1:0]       mem [DEPTH];

  logic                wr_en, rd_en, out_ready, skid_next, trig_ev, cfg_legal;
  logic [CW:0]         cfg_sum;
  logic [CW-1:0]       cnt_inc;

  // Handshake: a beat transfers on a rising sys_clk edge where m_valid && m_ready;
  // m_valid/m_data/m_last are registered and never change while m_valid && !m_ready.
  assign out_ready = !m_valid_q || m_ready;
  // Skid occupancy next cycle; a read is issued only if the skid will be empty,
  // so the returning RAM word always has somewhere to land.
  assign skid_next = (skid_valid_q && !(out_ready && !rvalid_q)) ||
                     (rvalid_q && (!out_ready || skid_valid_q));
  assign trig_ev   = trig_sw || (trig_in && !trig_q);
  assign cfg_sum   = {1'b0, cfg_pre} + {1'b0, cfg_post};
  assign cfg_legal = (cfg_sum != '0) && (cfg_sum <= DEPTH_L);
  assign cnt_inc   = cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    pre_d        = pre_q;
    post_d       = post_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    wptr_d       = wptr_q;
    trig_addr_d  = trig_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_left_d    = rd_left_q;
    cfg_err_d    = cfg_err_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    rvalid_d     = 1'b0;
    rlast_d      = 1'b0;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    skid_valid_d = skid_next;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;

    if (out_ready) begin
      m_valid_d = skid_valid_q || rvalid_q;
      if (skid_valid_q) begin
        m_data_d = skid_data_q;
        m_last_d = skid_last_q;
      end else if (rvalid_q) begin
        m_data_d = ram_q;
        m_last_d = rlast_q;
      end else begin
        m_last_d = 1'b0;
      end
    end
    if (rvalid_q && (skid_valid_q || !out_ready)) begin
      skid_data_d = ram_q;
      skid_last_d = rlast_q;
    end

    if (state_q == ST_READ && rd_left_q != '0 && !skid_next) begin
      rd_en     = 1'b1;
      rvalid_d  = 1'b1;
      rlast_d   = (rd_left_q == CW'(1));
      rd_addr_d = rd_addr_q + ADDR_W'(1);
      rd_left_d = rd_left_q - CW'(1);
    end

    if (abort) begin
      state_d      = ST_IDLE;
      m_valid_d    = 1'b0;
      m_last_d     = 1'b0;
      skid_valid_d = 1'b0;
      rvalid_d     = 1'b0;
      rlast_d      = 1'b0;
      rd_en        = 1'b0;
      rd_addr_d    = rd_addr_q;
      rd_left_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            if (cfg_legal) begin
              pre_d     = cfg_pre;
              post_d    = cfg_post;
              len_d     = cfg_sum[CW-1:0];
              cnt_d     = '0;
              cfg_err_d = 1'b0;
              state_d   = (cfg_pre != '0) ? ST_PRE : ST_WAIT;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_PRE: begin
          if (s_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) begin
              cnt_d   = '0;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (trig_ev) begin
            trig_addr_d = wptr_q;
            rd_addr_d   = wptr_q - pre_q[ADDR_W-1:0];
            rd_left_d   = len_q;
            // With no post window the trigger-cycle beat is not part of the capture.
            if (post_q == '0) begin
              state_d = ST_READ;
            end else if (s_valid) begin
              wr_en   = 1'b1;
              cnt_d   = CW'(1);
              state_d = (post_q == CW'(1)) ? ST_READ : ST_POST;
            end else begin
              cnt_d   = '0;
              state_d = ST_POST;
            end
          end else if (s_valid) begin
            wr_en = 1'b1;
          end
        end
        ST_POST: begin
          if (s_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc == post_q) state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (m_valid_q && m_ready && m_last_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (wr_en) wptr_d = wptr_q + ADDR_W'(1);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pre_q        <= '0;
      post_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      trig_addr_q  <= '0;
      rd_addr_q    <= '0;
      rd_left_q    <= '0;
      trig_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      post_q       <= post_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      trig_addr_q  <= trig_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_left_q    <= rd_left_d;
      trig_q       <= trig_in;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      cfg_err_q    <= cfg_err_d;
      done_q       <= done_d;
    end
  end

  // Sample storage: no reset, contents only meaningful after a capture.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wptr_q] <= s_data;
    if (rd_en) ram_q <= mem[rd_addr_q];
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign busy      = (state_q != ST_IDLE);
  assign state     = state_q;
  assign trig_addr = trig_addr_q;
  assign cfg_err   = cfg_err_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fmc_adc_acq_trig_buf.sv
// Directed bench: capture table (normal, wrap, pre/post boundaries, backpressure)
// plus hand sequences for config error, held trigger, abort and reset mid-readout.
module tb_fmc_adc_acq_trig_buf;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DW     = 16 * NUM_CH;

  logic              sys_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [DW-1:0]     s_data = '0;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              trig_in = 1'b0;
  logic              trig_sw = 1'b0;
  logic [ADDR_W:0]   cfg_pre = '0;
  logic [ADDR_W:0]   cfg_post = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DW-1:0]     m_data;
  logic              m_last;
  logic              busy;
  logic [2:0]        state;
  logic [ADDR_W-1:0] trig_addr;
  logic              cfg_err;
  logic              done;

  fmc_adc_acq_trig_buf #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .arm(arm), .abort(abort), .trig_in(trig_in), .trig_sw(trig_sw),
    .cfg_pre(cfg_pre), .cfg_post(cfg_post), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .state(state),
    .trig_addr(trig_addr), .cfg_err(cfg_err), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         pre;
    int         post;
    int         trig_beat;
    bit         hw;
    logic [3:0] rdy_pat;
    int         exp_taddr;
    int         exp_first;
    int         exp_n;
  } vec_t;

  vec_t          vecs[6];
  int            n_vec = 0;
  int            n_err = 0;
  int            beat_n = 0;
  logic [DW-1:0] exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_sw = 1'b0; trig_in = 1'b0;
    s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
  endtask

  task automatic arm_cycle(input int pre, input int post);
    @(negedge sys_clk);
    cfg_pre = (ADDR_W+1)'(pre); cfg_post = (ADDR_W+1)'(post);
    arm = 1'b1; s_valid = 1'b0; trig_sw = 1'b0; abort = 1'b0;
    beat_n = 0;
  endtask

  // Drives beat beat_n for the coming rising edge; outputs seen after return reflect the previous edge.
  task automatic next_beat(input bit sw, input bit tin, input bit ab);
    @(negedge sys_clk);
    arm = 1'b0;
    s_valid = 1'b1;
    s_data = {16'(beat_n + 256), 16'(beat_n)};
    trig_sw = sw; trig_in = tin; abort = ab;
    beat_n++;
  endtask

  task automatic run_capture(input vec_t v, input bit do_rst, input string tag);
    int read_cyc = -1, first_valid = -1, first_acc = -1, last_acc = -1;
    int done_cyc = -1, done_cnt = 0, acc_cnt = 0, stab_bad = 0;
    logic hold = 1'b0;
    logic hold_last = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic [DW-1:0] e;
    if (do_rst) do_reset();
    trig_in = 1'b0; m_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < v.exp_n; i++)
      exp_q.push_back({16'(v.exp_first + i + 256), 16'(v.exp_first + i)});
    arm_cycle(v.pre, v.post);
    for (int cyc = 0; cyc < 300; cyc++) begin
      next_beat(!v.hw && beat_n == v.trig_beat, v.hw && beat_n >= v.trig_beat, 1'b0);
      m_ready = v.rdy_pat[cyc % 4];
      if (hold && !(m_valid === 1'b1 && m_data === hold_data && m_last === hold_last)) stab_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (state == 3'd4 && read_cyc < 0) read_cyc = cyc;
      if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (m_valid === 1'b1 && m_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL %s extra beat: got %0h expected none", tag, m_data);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s beat%0d data", tag, acc_cnt - 1), m_data, e);
          chk($sformatf("%s beat%0d last", tag, acc_cnt - 1), m_last, exp_q.size() == 0);
        end
      end
      hold = (m_valid === 1'b1) && !m_ready;
      hold_data = m_data; hold_last = m_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    m_ready = 1'b0;
    chk({tag, " beat count"}, acc_cnt, v.exp_n);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " done timing"}, done_cyc, last_acc + 1);
    chk({tag, " trig_addr"}, trig_addr, v.exp_taddr);
    chk({tag, " first valid latency"},
        (read_cyc >= 0 && first_valid >= read_cyc && first_valid - read_cyc <= 2), 1);
    chk({tag, " stall stability"}, stab_bad, 0);
    if (v.rdy_pat == 4'hF) chk({tag, " no bubbles"}, last_acc - first_acc, v.exp_n - 1);
    chk({tag, " end state"}, state, 0);
  endtask

  initial begin
    vec_t v;
    int cnt_v, cnt_d;
    bit seen;
    vecs[0] = '{4, 4, 10, 1'b0, 4'hF, 10, 6, 8};
    vecs[1] = '{8, 8, 37, 1'b1, 4'hF, 5, 29, 16};
    vecs[2] = '{0, 16, 3, 1'b0, 4'hF, 3, 3, 16};
    vecs[3] = '{16, 0, 20, 1'b0, 4'hF, 4, 4, 16};
    vecs[4] = '{4, 4, 10, 1'b0, 4'b1001, 10, 6, 8};
    vecs[5] = '{1, 1, 5, 1'b0, 4'hF, 5, 4, 2};

    do_reset();
    chk("reset ctrl", {m_valid, m_last, busy, done, cfg_err, state, trig_addr}, 0);
    chk("reset data", m_data, 0);

    for (int i = 0; i < 6; i++) run_capture(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Illegal configurations, then a legal arm clears the sticky error.
    do_reset();
    arm_cycle(10, 10);
    next_beat(1'b0, 1'b0, 1'b0);
    chk("cfg 10+10 err", cfg_err, 1);
    chk("cfg 10+10 state", state, 0);
    chk("cfg 10+10 busy", busy, 0);
    arm_cycle(0, 0);
    next_beat(1'b0, 1'b0, 1'b0);
    chk("cfg 0+0 err", cfg_err, 1);
    chk("cfg 0+0 state", state, 0);
    v = '{2, 2, 6, 1'b0, 4'hF, 6, 4, 4};
    run_capture(v, 1'b0, "cfg legal");
    chk("cfg legal err cleared", cfg_err, 0);

    // Trigger input already high when armed must not fire until it toggles.
    do_reset();
    trig_in = 1'b1;
    arm_cycle(2, 2);
    for (int i = 0; i < 10; i++) next_beat(1'b0, 1'b1, 1'b0);
    chk("held trig waits", state, 2);
    next_beat(1'b0, 1'b0, 1'b0);
    next_beat(1'b0, 1'b1, 1'b0);
    next_beat(1'b0, 1'b1, 1'b0);
    chk("retrig state post", state, 3);
    chk("retrig trig_addr", trig_addr, 11);
    next_beat(1'b0, 1'b1, 1'b1);
    next_beat(1'b0, 1'b0, 1'b0);
    chk("retrig abort state", state, 0);

    // Abort after two post beats: straight to idle, no output, no done.
    do_reset();
    arm_cycle(4, 4);
    for (int i = 0; i < 12; i++) next_beat(beat_n == 10, 1'b0, 1'b0);
    next_beat(1'b0, 1'b0, 1'b1);
    chk("abort pre state", state, 3);
    next_beat(1'b0, 1'b0, 1'b0);
    chk("abort state", state, 0);
    chk("abort m_valid", m_valid, 0);
    chk("abort busy", busy, 0);
    m_ready = 1'b1;
    cnt_v = 0; cnt_d = 0;
    for (int i = 0; i < 30; i++) begin
      next_beat(1'b0, 1'b0, 1'b0);
      if (m_valid === 1'b1) cnt_v++;
      if (done === 1'b1) cnt_d++;
    end
    m_ready = 1'b0;
    chk("abort no output", cnt_v, 0);
    chk("abort no done", cnt_d, 0);

    // Asynchronous reset in the middle of readout, then a fresh identical capture.
    do_reset();
    arm_cycle(4, 4);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      next_beat(beat_n == 10, 1'b0, 1'b0);
      if (m_valid === 1'b1 && state == 3'd4) seen = 1'b1;
    end
    chk("midread reached", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset ctrl", {m_valid, m_last, busy, done, cfg_err, state, trig_addr}, 0);
    chk("async reset data", m_data, 0);
    s_valid = 1'b0; trig_sw = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    run_capture(vecs[0], 1'b0, "after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fmc_adc_acq_trig_buf.md
Name: fmc_adc_acq_trig_buf

Overview:
- Parametrised pre/post-trigger capture buffer for the FMC ADC 250M 4CH data path, in the sys_clk domain downstream of the per-ADC clock-domain crossing.
- Accepts NUM_CH packed 16-bit samples per beat and keeps a circular history while armed.
- On a hardware or software trigger, captures a configurable post-trigger window, then streams pre+post samples out over a valid/ready interface.

Parameters:
- NUM_CH, 4, ADC channels per beat; each channel is 16 bits.
- DEPTH, 1024, buffer depth in beats; must be a power of two, at least 4.
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden).

Ports:
- sys_clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid (no backpressure).
- s_data  in  16*NUM_CH  channel k occupies bits [16k+15:16k].
- arm  in  1  level; sampled in IDLE to start a capture.
- abort  in  1  synchronous abort, one-cycle pulse.
- trig_in  in  1  hardware trigger level; rising edge detected internally.
- trig_sw  in  1  software trigger, one-cycle pulse.
- cfg_pre  in  ADDR_W+1  pre-trigger beats, latched on arm.
- cfg_post  in  ADDR_W+1  post-trigger beats, latched on arm.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat accept.
- m_data  out  16*NUM_CH  output beat.
- m_last  out  1  high with the final beat.
- busy  out  1  high in any state other than IDLE.
- state  out  3  IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, READ=4.
- trig_addr  out  ADDR_W  buffer address of the first post-trigger beat.
- cfg_err  out  1  sticky; set on an arm with an illegal config, cleared by the next legal arm.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: all outputs 0; state=IDLE; write pointer=0; trigger edge register=0.
- Config legality: 1 <= cfg_pre+cfg_post <= DEPTH.
  - Illegal config with arm=1 in IDLE: cfg_err<=1, stay in IDLE.
  - Legal config: cfg_pre and cfg_post are latched, counters cleared. Next state is PRE if pre>0, otherwise WAIT_TRIG.
- Writes: in PRE, WAIT_TRIG and POST, each s_valid beat is written at wptr and wptr increments modulo DEPTH (wraps freely). s_valid is ignored in IDLE and READ.
- PRE: counts written beats; the cycle that writes beat number pre moves to WAIT_TRIG. Triggers seen in PRE are ignored, not queued.
- Trigger event: trig_sw=1, or trig_in=1 with its registered copy=0. Only qualified in WAIT_TRIG. trig_in already high on entry to WAIT_TRIG produces no event until it falls and rises again.
- WAIT_TRIG on a trigger event:
  - trig_addr<=wptr; that wptr is also the write address of the same-cycle s_valid beat, if any.
  - If the same cycle has s_valid, that beat is post beat 0.
  - Next state is POST if post>0, otherwise READ.
  - With post=1 and s_valid in the trigger cycle, go directly to READ.
- POST: counts post beats, including one written in the trigger cycle; moves to READ after beat number post is written.
- READ:
  - Read address starts at (trig_addr - pre) mod DEPTH and increments modulo DEPTH over pre+post beats.
  - Synchronous RAM with 1-cycle read latency; an output register plus a one-entry skid provide full throughput.
  - m_valid/m_data/m_last hold stable while m_ready=0. No bubbles while m_ready stays high after the first beat.
  - First m_valid appears no later than 2 cycles after entering READ.
  - On acceptance of the m_last beat: done=1 for one cycle, state->IDLE.
- abort: from any state, next state is IDLE; m_valid, m_last and skid are cleared; no done pulse. abort wins over a trigger or arm in the same cycle.
- rst_n deasserted mid-operation: immediate return to reset values; buffer contents are undefined and never read without a new capture.
- Storage: one inferred simple dual-port RAM, DEPTH x 16*NUM_CH; no reset on the array.

Test Plan:
All cases use DEPTH=16, NUM_CH=2, s_data={ch1=n+0x100, ch0=n} for beat n, with s_valid continuous from n=0.
1. Basic: pre=4, post=4, arm at n=0, trig_sw with beat 10 -> trig_addr=10; output ch0 = 6,7,8,9,10,11,12,13; m_last on 13; done one cycle later; m_ready=1 gives 8 consecutive beats.
2. Wrap: pre=8, post=8, hardware trigger (trig_in rising) with beat 37 -> trig_addr=5; output ch0 = 29..44 in order, read address wrapping 13..15,0..12; m_last on 44.
3. Edge cases:
   - pre=0, post=16, trig_sw with beat 3 -> output 3..18.
   - pre=16, post=0, trigger at beat 20 -> output 4..19 (post=0 trigger beat not captured).
   - trig_in held high from arm -> no capture until toggled.
4. Config error: pre=10, post=10, arm -> cfg_err=1, state stays 0, busy=0. Then pre=2, post=2, arm -> cfg_err=0, capture proceeds.
5. Backpressure: case 1 config, m_ready toggling 1,0,0,1 pattern -> every beat delivered exactly once, in order, data stable while stalled, m_last only on 13.
6. Abort/reset: abort in POST after 2 post beats -> state=0 next cycle, m_valid=0, no done. rst_n low mid-READ -> all outputs 0 asynchronously; a fresh capture then reproduces case 1 exactly.
